abs_pos_calc_engine: RTL and testbench

Responder side of the absolute-position calculation handshake. It accepts one axis's hardware counter, set position and counts-per-metre from the absolute-position state machine on `start_hls_calculations`, and computes the absolute position in nanometres with a multi-cycle multiply and divide. It returns the result with `hls_done`/`hls_ready`. It replaces the HLS core in the position datapath and sits directly beside the state machine that selects the axis.

---
 rtl/abs_pos_calc_engine.sv | 196 +++++++++++++++++++
 tb/tb_abs_pos_calc_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/abs_pos_calc_engine.sv
// abs_pos_calc_engine
// Responder side of the absolute-position calculation handshake. Captures one
// axis's hardware counter, set position and counts-per-metre on a start
// request and returns
//    set_position + trunc(hw_counter * NM_PER_M / counts_per_m)   (mod 2^64)
// after a fixed 66-cycle latency (1 multiply cycle, 64 divide cycles, 1 add).
//
// Optional build macro:
//   ABS_POS_ROUND_EN  round the quotient magnitude half away from zero
//                     instead of truncating (same latency and interface).
//
// Ports:
//   clk                               clock, rising edge
//   rst                               synchronous active-low reset
//   start_hls_calculations            request, sampled only while hls_ready=1
//   selected_axis_hw_counter          signed counts
//   selected_axis_set_position_part1  set position [31:0], nm
//   selected_axis_set_position_part2  set position [63:32], nm (signed 64-bit)
//   selected_axis_counts_per_m        unsigned divisor
//   hls_ready                         idle, able to accept a start
//   hls_done                          one-cycle result-valid pulse
//   selected_axis_hls_calculated_abs_pos  signed result, nm, held until next done
//   div_by_zero                       last result was computed with divisor 0
module abs_pos_calc_engine #(
   parameter int unsigned NM_PER_M = 32'd1000000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_hls_calculations,
   input  logic [31:0] selected_axis_hw_counter,
   input  logic [31:0] selected_axis_set_position_part1,
   input  logic [31:0] selected_axis_set_position_part2,
   input  logic [31:0] selected_axis_counts_per_m,
   output logic        hls_ready,
   output logic        hls_done,
   output logic [63:0] selected_axis_hls_calculated_abs_pos,
   output logic        div_by_zero
);

   localparam int unsigned CNT_W = 6;
   localparam logic [29:0] NM_C  = 30'(NM_PER_M);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MULT = 2'd1,
      S_DIV  = 2'd2,
      S_ADD  = 2'd3
   } state_t;

   state_t state_q, state_d;

   // captured operands
   logic [31:0] hw_q,  hw_d;
   logic [63:0] sp_q,  sp_d;
   logic [31:0] cpm_q, cpm_d;

   // divider: quo_q starts as the dividend and shifts quotient bits in at the bottom
   logic [63:0]      quo_q, quo_d;
   logic [31:0]      rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // registered outputs
   logic        ready_q,  ready_d;
   logic        done_q,   done_d;
   logic [63:0] result_q, result_d;
   logic        dz_q,     dz_d;

   logic        accept;
   logic [31:0] hw_mag;
   logic [63:0] product;
   logic [32:0] rem_shift;
   logic        rem_ge;
   logic [63:0] q_mag;
   logic [63:0] q_signed;

   assign accept = ready_q && start_hls_calculations;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_MULT;
         S_MULT:  state_d = S_DIV;
         S_DIV:   if (cnt_q == CNT_W'(63)) state_d = S_ADD;
         S_ADD:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Magnitude of the counter; -2^31 maps to 2^31, which still fits 32 bits unsigned
   assign hw_mag    = hw_q[31] ? 32'(32'd0 - hw_q) : hw_q;
   assign product   = 64'(hw_mag) * 64'(NM_C);
   assign rem_shift = {rem_q, quo_q[63]};
   assign rem_ge    = rem_shift >= {1'b0, cpm_q};

   // Quotient magnitude with optional round-half-away-from-zero
   always_comb begin
      q_mag = quo_q;
`ifdef ABS_POS_ROUND_EN
      if ((cpm_q != 32'd0) && ({rem_q, 1'b0} >= {1'b0, cpm_q})) begin
         q_mag = quo_q + 64'd1;
      end
`endif
      q_signed = hw_q[31] ? 64'(64'd0 - q_mag) : q_mag;
   end

   // Output and datapath next values
   always_comb begin
      hw_d     = hw_q;
      sp_d     = sp_q;
      cpm_d    = cpm_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      ready_d  = ready_q;
      done_d   = 1'b0;
      result_d = result_q;
      dz_d     = dz_q;
      case (state_q)
         S_IDLE: begin
            // ready rises one cycle after reset release, so that edge never accepts
            ready_d = 1'b1;
            if (accept) begin
               ready_d = 1'b0;
               hw_d    = selected_axis_hw_counter;
               sp_d    = {selected_axis_set_position_part2, selected_axis_set_position_part1};
               cpm_d   = selected_axis_counts_per_m;
            end
         end
         S_MULT: begin
            quo_d = product;
            rem_d = 32'd0;
            cnt_d = '0;
         end
         S_DIV: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cpm_q == 32'd0) begin
               // shift the dividend out and zeros in: quotient ends as 0
               quo_d = {quo_q[62:0], 1'b0};
            end else begin
               quo_d = {quo_q[62:0], rem_ge};
               rem_d = rem_ge ? 32'(rem_shift - {1'b0, cpm_q}) : rem_shift[31:0];
            end
         end
         S_ADD: begin
            result_d = sp_q + q_signed;
            dz_d     = (cpm_q == 32'd0);
            done_d   = 1'b1;
            ready_d  = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         hw_q     <= '0;
         sp_q     <= '0;
         cpm_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         dz_q     <= 1'b0;
      end else begin
         hw_q     <= hw_d;
         sp_q     <= sp_d;
         cpm_q    <= cpm_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         result_q <= result_d;
         dz_q     <= dz_d;
      end
   end

   assign hls_ready                            = ready_q;
   assign hls_done                             = done_q;
   assign selected_axis_hls_calculated_abs_pos = result_q;
   assign div_by_zero                          = dz_q;

endmodule

// File: tb/tb_abs_pos_calc_engine.sv
// Testbench for abs_pos_calc_engine: directed vector table, randomized runs
// against an arithmetic reference model, and handshake/reset sequences.
module tb_abs_pos_calc_engine;

   localparam logic [63:0] NM = 64'd1000000000;
   localparam int          LAT = 66;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] hw = '0;
   logic [31:0] sp1 = '0;
   logic [31:0] sp2 = '0;
   logic [31:0] cpm = '0;
   logic        hls_ready;
   logic        hls_done;
   logic [63:0] res_o;
   logic        dz_o;

   int checks   = 0;
   int failures = 0;

   abs_pos_calc_engine dut (
      .clk                                  (clk),
      .rst                                  (rst),
      .start_hls_calculations               (start),
      .selected_axis_hw_counter             (hw),
      .selected_axis_set_position_part1     (sp1),
      .selected_axis_set_position_part2     (sp2),
      .selected_axis_counts_per_m           (cpm),
      .hls_ready                            (hls_ready),
      .hls_done                             (hls_done),
      .selected_axis_hls_calculated_abs_pos (res_o),
      .div_by_zero                          (dz_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hw;
      logic [63:0] sp;
      logic [31:0] cpm;
      logic [63:0] exp_res;
      logic        exp_dz;
   } vec_t;

   vec_t tv[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
      end
   endtask

   // Reference: magnitude arithmetic, divide, sign, add. Returns {div_by_zero, result}.
   function automatic logic [64:0] model(input logic [31:0] h, input logic [63:0] s,
                                         input logic [31:0] c);
      logic [63:0] mag, p, q, r;
      logic        neg;
      neg = h[31];
      mag = neg ? (64'd0 - {{32{h[31]}}, h}) : {32'd0, h};
      p   = mag * NM;
      if (c == 32'd0) return {1'b1, s};
      q = p / {32'd0, c};
      r = p % {32'd0, c};
`ifdef ABS_POS_ROUND_EN
      if ((r * 64'd2) >= {32'd0, c}) q = q + 64'd1;
`endif
      return {1'b0, s + (neg ? (64'd0 - q) : q)};
   endfunction

   // One transaction; lat counts edges after the capture edge until hls_done is seen.
   task automatic do_run(input logic [31:0] h, input logic [63:0] s, input logic [31:0] c,
                         input bit scramble, output int lat, output logic [63:0] r,
                         output logic d);
      int w;
      w = 0;
      @(posedge clk); #1;
      while (!hls_ready && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      hw = h; sp1 = s[31:0]; sp2 = s[63:32]; cpm = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (scramble) begin
         hw = $urandom; sp1 = $urandom; sp2 = $urandom; cpm = $urandom;
      end
      lat = 0;
      while (lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (hls_done) break;
      end
      r = res_o;
      d = dz_o;
   endtask

   initial begin
      int          lat;
      logic [63:0] r;
      logic        d;
      logic [64:0] m;
      int          ndone;
      int          dedge[3];
      logic [31:0] rh, rc;
      logic [63:0] rs;

      tv[0] = '{32'd1000, 64'd5000000, 32'd1000000, 64'd6000000, 1'b0};
`ifdef ABS_POS_ROUND_EN
      tv[1] = '{32'd2, 64'd0, 32'd3, 64'd666666667, 1'b0};
`else
      tv[1] = '{32'd2, 64'd0, 32'd3, 64'd666666666, 1'b0};
`endif
      tv[2] = '{32'hFFFF_FFF9, 64'd0, 32'd3, 64'(-64'sd2333333333), 1'b0};
      tv[3] = '{32'd12345, 64'h0000_0001_0000_0000, 32'd0, 64'h0000_0001_0000_0000, 1'b1};
      tv[4] = '{32'h8000_0000, 64'd0, 32'd1, 64'(-64'sd2147483648000000000), 1'b0};
      tv[5] = '{32'd1, 64'h7FFF_FFFF_FFFF_FFFF, 32'd1000000000, 64'h8000_0000_0000_0000, 1'b0};
`ifdef ABS_POS_ROUND_EN
      tv[6] = '{32'd1, 64'd0, 32'd2000000000, 64'd1, 1'b0};
      tv[7] = '{32'hFFFF_FFFF, 64'd100, 32'd2000000000, 64'd99, 1'b0};
      tv[8] = '{32'h7FFF_FFFF, 64'd0, 32'hFFFF_FFFF, 64'd500000000, 1'b0};
`else
      tv[6] = '{32'd1, 64'd0, 32'd2000000000, 64'd0, 1'b0};
      tv[7] = '{32'hFFFF_FFFF, 64'd100, 32'd2000000000, 64'd100, 1'b0};
      tv[8] = '{32'h7FFF_FFFF, 64'd0, 32'hFFFF_FFFF, 64'd499999999, 1'b0};
`endif

      // Reset and idle
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("rst_ready",  64'(hls_ready), 64'd0);
      chk("rst_done",   64'(hls_done),  64'd0);
      chk("rst_result", res_o,          64'd0);
      chk("rst_dz",     64'(dz_o),      64'd0);

      // Release with start already high: the first released edge must not accept
      rst = 1'b1; start = 1'b1;
      hw = 32'd1000; sp1 = 32'd5000000; sp2 = 32'd0; cpm = 32'd1000000;
      @(posedge clk); #1;
      chk("rel_ready_up", 64'(hls_ready), 64'd1);
      chk("rel_no_done",  64'(hls_done),  64'd0);
      @(posedge clk); #1;
      chk("rel_captured", 64'(hls_ready), 64'd0);
      start = 1'b0;
      lat = 0;
      while (lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (hls_done) break;
      end
      chk("basic_lat", 64'(lat), 64'(LAT));
      chk("basic_res", res_o, 64'd6000000);
      chk("basic_ready_with_done", 64'(hls_ready), 64'd1);
      @(posedge clk); #1;
      chk("basic_done_pulse", 64'(hls_done), 64'd0);

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         do_run(tv[i].hw, tv[i].sp, tv[i].cpm, 1'b0, lat, r, d);
         chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT));
         chk($sformatf("vec%0d_res", i), r, tv[i].exp_res);
         chk($sformatf("vec%0d_dz", i), 64'(d), 64'(tv[i].exp_dz));
      end

      // Random runs with inputs scrambled after capture
      for (int i = 0; i < 24; i++) begin
         rh = $urandom;
         rs = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       rc = 32'd0;
            1:       rc = $urandom_range(1, 16);
            2:       rc = $urandom;
            default: rc = $urandom_range(1, 1000000);
         endcase
         m = model(rh, rs, rc);
         do_run(rh, rs, rc, 1'b1, lat, r, d);
         chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(LAT));
         chk($sformatf("rnd%0d_res", i), r, m[63:0]);
         chk($sformatf("rnd%0d_dz", i), 64'(d), 64'(m[64]));
      end

      // Start pulse during a busy run is ignored
      m = model(32'd777, 64'd42, 32'd13);
      hw = 32'd777; sp1 = 32'd42; sp2 = 32'd0; cpm = 32'd13; start = 1'b1;
      ndone = 0; dedge[0] = -1;
      for (int e = 0; e < 250; e++) begin
         @(posedge clk); #1;
         if (e == 0) start = 1'b0;
         if (hls_done) begin
            if (ndone == 0) dedge[0] = e;
            ndone++;
         end
         if (e == 10) begin
            hw = 32'd5; sp1 = 32'd0; cpm = 32'd1; start = 1'b1;
         end
         if (e == 11) start = 1'b0;
      end
      chk("busy_done_count", 64'(ndone), 64'd1);
      chk("busy_lat", 64'(dedge[0]), 64'(LAT));
      chk("busy_res", res_o, m[63:0]);

      // Start held high: back-to-back runs (divide-by-zero operands)
      m = model(32'd99, 64'h0000_0012_3456_789A, 32'd0);
      hw = 32'd99; sp1 = 32'h3456_789A; sp2 = 32'h0000_0012; cpm = 32'd0; start = 1'b1;
      ndone = 0;
      for (int k = 0; k < 3; k++) dedge[k] = -1;
      for (int e = 0; e < 260; e++) begin
         @(posedge clk); #1;
         if (hls_done) begin
            if (ndone < 3) dedge[ndone] = e;
            ndone++;
            if (ndone < 4) begin
               chk($sformatf("b2b%0d_res", ndone), res_o, m[63:0]);
               chk($sformatf("b2b%0d_dz", ndone), 64'(dz_o), 64'd1);
            end
            if (ndone == 3) start = 1'b0;
         end
      end
      chk("b2b_count", 64'(ndone), 64'd3);
      chk("b2b_first_lat", 64'(dedge[0]), 64'(LAT));
      chk("b2b_gap1", 64'(dedge[1] - dedge[0]), 64'(LAT + 1));
      chk("b2b_gap2", 64'(dedge[2] - dedge[1]), 64'(LAT + 1));

      // Reset in the middle of the divide
      hw = 32'd321; sp1 = 32'd9; sp2 = 32'd0; cpm = 32'd7; start = 1'b1;
      ndone = 0;
      for (int e = 0; e < 150; e++) begin
         @(posedge clk); #1;
         if (e == 0) start = 1'b0;
         if (hls_done) ndone++;
         if (e == 31) rst = 1'b0;
         if (e == 32) begin
            chk("midrst_ready",  64'(hls_ready), 64'd0);
            chk("midrst_done",   64'(hls_done),  64'd0);
            chk("midrst_result", res_o,          64'd0);
            chk("midrst_dz",     64'(dz_o),      64'd0);
            rst = 1'b1;
         end
         if (e == 33) chk("midrst_ready_up", 64'(hls_ready), 64'd1);
      end
      chk("midrst_no_done", 64'(ndone), 64'd0);
      chk("midrst_result_held", res_o, 64'd0);

      m = model(32'hFFFF_F000, 64'd123456789, 32'd4096);
      do_run(32'hFFFF_F000, 64'd123456789, 32'd4096, 1'b0, lat, r, d);
      chk("after_rst_lat", 64'(lat), 64'(LAT));
      chk("after_rst_res", r, m[63:0]);
      chk("after_rst_dz",  64'(d), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
